decoder_n_scan: RTL

Parametrised, registered N-to-2^N one-hot select driver; successor to the combinational 3-to-8 decoder. It adds a valid/ready request port, a programmable dwell time per select, and an auto-scan mode that steps the one-hot output through all positions with wrap-around. It sits between a controller and row/column-select lines that must be driven glitch-free from flops.

---
 rtl/decoder_n_scan_pkg.sv | 15 +
 rtl/decoder_n_scan_if.sv | 30 +++
 rtl/decoder_n_scan_onehot.sv | 19 +
 rtl/decoder_n_scan.sv | 130 +++++++++++++
 4 files changed

// File: rtl/decoder_n_scan_pkg.sv
// Shared types for the registered one-hot select driver (decoder_n_scan).
// FSM state encoding and the OUT_W = 2**IN_W width helper.
package dec_scan_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StScan
    } state_e;

    function automatic int unsigned out_width(input int unsigned in_w);
        return 32'd1 << in_w;
    endfunction

endpackage

// File: rtl/decoder_n_scan_if.sv
// Request/select bundle between a controller (master) and decoder_n_scan (slave).
interface decoder_n_scan_if #(
    parameter int unsigned IN_W = 3,
    parameter int unsigned DW_W = 4
);
    import dec_scan_pkg::*;

    localparam int unsigned OUT_W = out_width(IN_W);

    logic            en;
    logic            mode;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_addr;
    logic [DW_W-1:0] dwell;
    logic [OUT_W-1:0] out;
    logic            busy;
    logic            scan_done;

    modport master (
        output en, mode, in_valid, in_addr, dwell,
        input  in_ready, out, busy, scan_done
    );

    modport slave (
        input  en, mode, in_valid, in_addr, dwell,
        output in_ready, out, busy, scan_done
    );

endinterface

// File: rtl/decoder_n_scan_onehot.sv
// Combinational IN_W-to-2**IN_W one-hot decoder; all-zero when disabled.
module dec_onehot
    import dec_scan_pkg::*;
#(
    parameter int unsigned IN_W = 3
) (
    input  logic [IN_W-1:0]            addr,
    input  logic                       en,
    output logic [out_width(IN_W)-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_n_scan.sv
// Registered one-hot select driver with dwell time and wrap-around auto-scan.
// Define DECODER_N_SCAN_BLANK_EN to insert an all-zero cycle between scan positions.
module decoder_n_scan
    import dec_scan_pkg::*;
#(
    parameter int unsigned IN_W = 3,
    parameter int unsigned DW_W = 4
) (
    input logic             clk,
    input logic             rst_n,
    decoder_n_scan_if.slave bus
);

    localparam int unsigned     OUT_W    = out_width(IN_W);
    localparam logic [IN_W-1:0] LastStep = IN_W'(OUT_W - 1);
    localparam logic [DW_W-1:0] One      = DW_W'(1);

    state_e            state_q;
    logic [OUT_W-1:0]  out_q;
    logic              busy_q;
    logic              done_q;
    logic [DW_W-1:0]   cnt_q;
    logic [DW_W-1:0]   dwell_q;
    logic [IN_W-1:0]   pos_q;
    logic [IN_W-1:0]   steps_q;
`ifdef DECODER_N_SCAN_BLANK_EN
    logic              blank_q;
`endif

    logic [IN_W-1:0]   dec_addr;
    logic [OUT_W-1:0]  dec_out;
    logic [DW_W-1:0]   dwell_eff;

    assign bus.in_ready  = (state_q == StIdle) && bus.en;
    assign bus.out       = out_q;
    assign bus.busy      = busy_q;
    assign bus.scan_done = done_q;

    assign dwell_eff = (bus.dwell == '0) ? One : bus.dwell;
    // Idle decodes the incoming address; otherwise the next scan position.
    assign dec_addr  = (state_q == StIdle) ? bus.in_addr : pos_q + IN_W'(1);

    dec_onehot #(
        .IN_W (IN_W)
    ) u_dec (
        .addr   (dec_addr),
        .en     (bus.en),
        .onehot (dec_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
            pos_q   <= '0;
            steps_q <= '0;
`ifdef DECODER_N_SCAN_BLANK_EN
            blank_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle && !bus.en) begin
                state_q <= StIdle;
                out_q   <= '0;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
`ifdef DECODER_N_SCAN_BLANK_EN
                blank_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    StIdle: begin
                        if (bus.in_valid && bus.en) begin
                            out_q   <= dec_out;
                            busy_q  <= 1'b1;
                            cnt_q   <= dwell_eff;
                            dwell_q <= dwell_eff;
                            pos_q   <= bus.in_addr;
                            steps_q <= '0;
                            state_q <= bus.mode ? StScan : StHold;
                        end
                    end
                    StHold: begin
                        if (cnt_q == One) begin
                            out_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q - One;
                        end
                    end
                    StScan: begin
`ifdef DECODER_N_SCAN_BLANK_EN
                        if (blank_q) begin
                            blank_q <= 1'b0;
                            out_q   <= dec_out;
                            pos_q   <= pos_q + IN_W'(1);
                            cnt_q   <= dwell_q;
                        end else
`endif
                        if (cnt_q != One) begin
                            cnt_q <= cnt_q - One;
                        end else if (steps_q == LastStep) begin
                            out_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            steps_q <= steps_q + IN_W'(1);
`ifdef DECODER_N_SCAN_BLANK_EN
                            out_q   <= '0;
                            blank_q <= 1'b1;
`else
                            out_q   <= dec_out;
                            pos_q   <= pos_q + IN_W'(1);
                            cnt_q   <= dwell_q;
`endif
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
